// File: rtl/rvfi_pc_chain_check.sv
// RVFI PC-continuity checker over a window of DEPTH+1 consecutive retired orders.
// Define RVFI_PC_CHAIN_ALIGN_CHECK_EN to add IALIGN alignment checking of captured PCs.
module rvfi_pc_chain_check #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NRET   = 2,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned IALIGN = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       check,
  input  logic [63:0]                base_order,
  input  logic [NRET-1:0]            rvfi_valid,
  input  logic [64*NRET-1:0]         rvfi_order,
  input  logic [XLEN*NRET-1:0]       rvfi_pc_rdata,
  input  logic [XLEN*NRET-1:0]       rvfi_pc_wdata,
  output logic [$clog2(DEPTH+1)-1:0] links_ok,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_kind,
  output logic [$clog2(DEPTH+1)-1:0] err_slot
);
  localparam int unsigned SW    = $clog2(DEPTH+1);
  localparam int unsigned NSLOT = DEPTH + 1;
  localparam logic [1:0] KIND_MISMATCH = 2'b01;
  localparam logic [1:0] KIND_DUP      = 2'b10;
  localparam logic [1:0] KIND_ALIGN    = 2'b11;

  typedef enum logic [1:0] {ST_COLLECT, ST_DONE, ST_FAIL} state_e;

  state_e            state_q, state_d;
  logic [NSLOT-1:0]  slot_vld_q;
  logic [XLEN-1:0]   rd_q [NSLOT];
  logic [XLEN-1:0]   wd_q [NSLOT];
  logic [DEPTH-1:0]  link_done_q;
  logic [SW-1:0]     links_ok_q, links_ok_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        err_kind_q, err_kind_d;
  logic [SW-1:0]     err_slot_q, err_slot_d;

  logic [63:0]       off_c      [NRET];
  logic [NRET-1:0]   in_win_c;
  logic [NSLOT-1:0]  slot_hit_c, slot_dup_c, vld_c, mis_align_c;
  logic [XLEN-1:0]   new_rd_c   [NSLOT];
  logic [XLEN-1:0]   new_wd_c   [NSLOT];
  logic [DEPTH-1:0]  link_eval_c;
  logic [NSLOT-1:0]  link_mis_c;
  logic [SW:0]       pass_cnt_c, links_sum_c;
  logic              err_new_c;
  logic [1:0]        sel_kind_c;
  logic [SW-1:0]     sel_slot_c;

  // Window offset per channel; modulo-2^64 subtraction makes order wrap-around legal.
  always_comb begin
    for (int c = 0; c < NRET; c++) begin
      off_c[c]    = rvfi_order[64*c +: 64] - base_order;
      in_win_c[c] = rvfi_valid[c] && (off_c[c] <= 64'(DEPTH));
    end
  end

  // Per-slot capture with bypass; a slot keeps its first contents on a duplicate.
  always_comb begin
    for (int s = 0; s < NSLOT; s++) begin
      slot_hit_c[s] = 1'b0;
      slot_dup_c[s] = 1'b0;
      new_rd_c[s]   = rd_q[s];
      new_wd_c[s]   = wd_q[s];
      for (int c = 0; c < NRET; c++) begin
        if (in_win_c[c] && (off_c[c][SW-1:0] == SW'(s))) begin
          if (slot_vld_q[s] || slot_hit_c[s]) begin
            slot_dup_c[s] = 1'b1;
          end else begin
            new_rd_c[s] = rvfi_pc_rdata[XLEN*c +: XLEN];
            new_wd_c[s] = rvfi_pc_wdata[XLEN*c +: XLEN];
          end
          slot_hit_c[s] = 1'b1;
        end
      end
      vld_c[s] = slot_vld_q[s] | slot_hit_c[s];
    end
  end

`ifdef RVFI_PC_CHAIN_ALIGN_CHECK_EN
  localparam logic [XLEN-1:0] ALIGN_MASK = (IALIGN == 16) ? XLEN'(1) : XLEN'(3);

  // Only contents captured this cycle are checked, so each slot is checked once.
  always_comb begin
    for (int s = 0; s < NSLOT; s++) begin
      mis_align_c[s] = slot_hit_c[s] && !slot_vld_q[s] &&
                       ((|(new_rd_c[s] & ALIGN_MASK)) || (|(new_wd_c[s] & ALIGN_MASK)));
    end
  end
`else
  logic unused_ialign;
  assign unused_ialign = (IALIGN == 16);
  assign mis_align_c   = '0;
`endif

  // Each link is evaluated once, in the first cycle both of its slots are valid.
  always_comb begin
    pass_cnt_c = '0;
    link_mis_c = '0;
    for (int k = 0; k < DEPTH; k++) begin
      link_eval_c[k] = !link_done_q[k] && vld_c[k] && vld_c[k+1];
      link_mis_c[k]  = link_eval_c[k] && (new_wd_c[k] != new_rd_c[k+1]);
      if (link_eval_c[k] && !link_mis_c[k]) pass_cnt_c = pass_cnt_c + (SW+1)'(1);
    end
    links_sum_c = {1'b0, links_ok_q} + pass_cnt_c;
    links_ok_d  = (links_sum_c > (SW+1)'(DEPTH)) ? SW'(DEPTH) : links_sum_c[SW-1:0];
  end

  // Error priority: lowest slot first, then mismatch over duplicate over misalign.
  always_comb begin
    err_new_c  = check && ((|link_mis_c) || (|slot_dup_c) || (|mis_align_c));
    sel_kind_c = 2'b00;
    sel_slot_c = '0;
    for (int s = NSLOT - 1; s >= 0; s--) begin
      if (mis_align_c[s]) begin sel_kind_c = KIND_ALIGN;    sel_slot_c = SW'(s); end
      if (slot_dup_c[s])  begin sel_kind_c = KIND_DUP;      sel_slot_c = SW'(s); end
      if (link_mis_c[s])  begin sel_kind_c = KIND_MISMATCH; sel_slot_c = SW'(s); end
    end
  end

  // Slot storage and link bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_vld_q  <= '0;
      link_done_q <= '0;
      links_ok_q  <= '0;
      for (int s = 0; s < NSLOT; s++) begin
        rd_q[s] <= '0;
        wd_q[s] <= '0;
      end
    end else begin
      slot_vld_q  <= vld_c;
      link_done_q <= link_done_q | link_eval_c;
      links_ok_q  <= links_ok_d;
      for (int s = 0; s < NSLOT; s++) begin
        rd_q[s] <= new_rd_c[s];
        wd_q[s] <= new_wd_c[s];
      end
    end
  end

  // FSM state register plus registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_COLLECT;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_kind_q <= 2'b00;
      err_slot_q <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_kind_q <= err_kind_d;
      err_slot_q <= err_slot_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: begin
        if (err_new_c)                       state_d = ST_FAIL;
        else if (links_ok_d == SW'(DEPTH))   state_d = ST_DONE;
      end
      ST_DONE:    if (check && (|slot_dup_c)) state_d = ST_FAIL;
      default:    state_d = ST_FAIL;
    endcase
  end

  // Output logic; error code is frozen on entry to FAIL.
  always_comb begin
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_FAIL);
    err_kind_d = err_kind_q;
    err_slot_d = err_slot_q;
    if ((state_q != ST_FAIL) && (state_d == ST_FAIL)) begin
      err_kind_d = sel_kind_c;
      err_slot_d = sel_slot_c;
    end
  end

  assign links_ok = links_ok_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_kind = err_kind_q;
  assign err_slot = err_slot_q;

`ifdef FORMAL
  always_comb begin
    if (!reset) begin
      assert (!(check && ((|link_mis_c) || (|slot_dup_c))));
      assert (!(check && (|mis_align_c)));
    end
  end
`endif

endmodule
